regfile_param: RTL and testbench

Parametrised multi-port register file for the RISC core, the next-generation register file for 16- and 32-bit datapath variants. It provides NUM_RD asynchronous read ports, one synchronous write port, optional write-to-read bypass and an optional hardwired-zero register 0. A per-register busy scoreboard supports multi-cycle producers, and a sequenced clear engine zeroes the file without asserting reset. It sits between decode (read addresses, reservations) and writeback (write port).

---
 rtl/regfile_param_pkg.sv | 18 +
 rtl/regfile_param_if.sv | 33 +++
 rtl/regfile_param_scoreboard.sv | 56 +++++
 rtl/regfile_param.sv | 101 ++++++++++
 tb/tb_regfile_param.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_param_pkg.sv
// Shared types and constants for the parametrised register file.
// Holds the clear-FSM encoding, default widths and the packed-port slice helper.
package rf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // Lowest bit of port `port` in a vector packing ports of `width` bits each.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port,
// reservation request and clear sweep control.
interface regfile_param_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_add;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_add;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_add;
  logic                     rsv_ok;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_add, wr_en, wr_add, wr_data, rsv_en, rsv_add, clr_req,
    input  rd_data, rd_busy, rsv_ok, clr_busy
  );

  modport slave (
    input  rd_add, wr_en, wr_add, wr_data, rsv_en, rsv_add, clr_req,
    output rd_data, rd_busy, rsv_ok, clr_busy
  );

endinterface

// File: rtl/regfile_param_scoreboard.sv
// Per-register busy scoreboard: reservations set, accepted writes and the
// clear sweep reset the busy bits; exports rsv_ok and per-port busy flags.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sweep,
  input  logic [ADDR_W-1:0]        sweep_add,
  input  logic                     wr_acc,
  input  logic [ADDR_W-1:0]        wr_add,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_add,
  input  logic [NUM_RD*ADDR_W-1:0] rd_add,
  output logic                     rsv_ok,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;

  always_comb begin
    rsv_ok = !sweep && !busy[rsv_add];
    if (ZERO_REG != 0 && rsv_add == '0) rsv_ok = 1'b0;
  end

  // Reservation is applied after the write clear so a same-cycle reserve wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (sweep) begin
      busy[sweep_add] <= 1'b0;
    end else begin
      if (wr_acc) busy[wr_add] <= 1'b0;
      if (rsv_en && rsv_ok) busy[rsv_add] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] rd_a;
    assign rd_a = rd_add[port_lsb(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rd_busy[i] = busy[rd_a];
      if (BYPASS != 0 && wr_acc && wr_add == rd_a) rd_busy[i] = 1'b0;
      if (ZERO_REG != 0 && rd_a == '0) rd_busy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with write bypass, optional zero
// register, busy scoreboard and a sequenced clear sweep.
//
//   state    | meaning
//   ST_IDLE  | normal operation; writes, reservations and clr_req accepted
//   ST_SWEEP | zeroing reg[cnt]/busy[cnt] one per cycle; bus inputs ignored
module regfile_param
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              sweep;
  logic              wr_acc;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clr_req) state_nxt = ST_SWEEP;
      ST_SWEEP: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep        = (state == ST_SWEEP);
    bus.clr_busy = sweep;
  end

  // Counter idles at 0 so the first sweep cycle clears register 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (sweep) cnt <= cnt + 1'b1;
    else            cnt <= '0;
  end

  assign wr_acc = bus.wr_en && !sweep && !(ZERO_REG != 0 && bus.wr_add == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (sweep) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_add] <= bus.wr_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_v;
    assign rd_a = bus.rd_add[port_lsb(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rd_v = mem[rd_a];
      if (BYPASS != 0 && wr_acc && bus.wr_add == rd_a) rd_v = bus.wr_data;
      if (ZERO_REG != 0 && rd_a == '0) rd_v = '0;
    end

    assign bus.rd_data[port_lsb(i, DATA_W) +: DATA_W] = rd_v;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .sweep     (sweep),
    .sweep_add (cnt),
    .wr_acc    (wr_acc),
    .wr_add    (bus.wr_add),
    .rsv_en    (bus.rsv_en),
    .rsv_add   (bus.rsv_add),
    .rd_add    (bus.rd_add),
    .rsv_ok    (bus.rsv_ok),
    .rd_busy   (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (BYPASS=1/ZERO_REG=0 and
// BYPASS=0/ZERO_REG=1) driven identically and compared with a behavioural model.
module tb_regfile_param;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NR    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Model: k=0 is the bypass instance, k=1 the zero-register instance.
  logic [DW-1:0] m_reg  [2][DEPTH];
  bit            m_busy [2][DEPTH];
  int            m_left [2];
  int            m_idx  [2];

  logic          we, re, cr;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  logic [AW-1:0] ad [NR];

  function automatic bit zr(input int k); return k == 1; endfunction
  function automatic bit bp(input int k); return k == 0; endfunction

  function automatic bit wacc(input int k);
    return we && m_left[k] == 0 && !(zr(k) && wa == 0);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    if (zr(k) && a == 0) return '0;
    if (bp(k) && wacc(k) && wa == a) return wd;
    return m_reg[k][a];
  endfunction

  function automatic bit exp_busy(input int k, input logic [AW-1:0] a);
    if (zr(k) && a == 0) return 1'b0;
    if (bp(k) && wacc(k) && wa == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic bit exp_rsv_ok(input int k);
    return m_left[k] == 0 && !m_busy[k][ra] && !(zr(k) && ra == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        m_reg[k][j]  = '0;
        m_busy[k][j] = 1'b0;
      end
      m_left[k] = 0;
      m_idx[k]  = 0;
    end
  endtask

  task automatic apply();
    bus0.wr_en = we;  bus0.wr_add = wa;  bus0.wr_data = wd;
    bus0.rsv_en = re; bus0.rsv_add = ra; bus0.clr_req = cr;
    bus1.wr_en = we;  bus1.wr_add = wa;  bus1.wr_data = wd;
    bus1.rsv_en = re; bus1.rsv_add = ra; bus1.clr_req = cr;
    for (int i = 0; i < NR; i++) begin
      bus0.rd_add[i*AW +: AW] = ad[i];
      bus1.rd_add[i*AW +: AW] = ad[i];
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk({tag, "/d0.rd_data"}, 32'(bus0.rd_data[i*DW +: DW]), 32'(exp_rd(0, ad[i])));
      chk({tag, "/d1.rd_data"}, 32'(bus1.rd_data[i*DW +: DW]), 32'(exp_rd(1, ad[i])));
      chk({tag, "/d0.rd_busy"}, 32'(bus0.rd_busy[i]), 32'(exp_busy(0, ad[i])));
      chk({tag, "/d1.rd_busy"}, 32'(bus1.rd_busy[i]), 32'(exp_busy(1, ad[i])));
    end
    chk({tag, "/d0.rsv_ok"},   32'(bus0.rsv_ok),   32'(exp_rsv_ok(0)));
    chk({tag, "/d1.rsv_ok"},   32'(bus1.rsv_ok),   32'(exp_rsv_ok(1)));
    chk({tag, "/d0.clr_busy"}, 32'(bus0.clr_busy), 32'(m_left[0] > 0));
    chk({tag, "/d1.clr_busy"}, 32'(bus1.clr_busy), 32'(m_left[1] > 0));
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc(input bit we_i, input logic [AW-1:0] wa_i, input logic [DW-1:0] wd_i,
                     input bit re_i, input logic [AW-1:0] ra_i, input bit cr_i,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
    bit acc [2];
    bit ok  [2];
    we = we_i; wa = wa_i; wd = wd_i; re = re_i; ra = ra_i; cr = cr_i;
    ad[0] = a0; ad[1] = a1;
    apply();
    #2;
    check_outputs(tag);
    for (int k = 0; k < 2; k++) begin
      acc[k] = wacc(k);
      ok[k]  = exp_rsv_ok(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_left[k] > 0) begin
        m_reg[k][m_idx[k]]  = '0;
        m_busy[k][m_idx[k]] = 1'b0;
        m_idx[k]++;
        m_left[k]--;
      end else begin
        if (acc[k]) begin
          m_reg[k][wa]  = wd;
          m_busy[k][wa] = 1'b0;
        end
        if (re && ok[k]) m_busy[k][ra] = 1'b1;
        if (cr) begin
          m_left[k] = DEPTH;
          m_idx[k]  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
    cyc(0, 0, 0, 0, 0, 0, a0, a1, tag);
  endtask

  task automatic read_all(input string tag);
    for (int j = 0; j < DEPTH; j += 2) idle(AW'(j), AW'(j + 1), tag);
  endtask

  initial begin
    int sweep_hi;
    we = 0; wa = 0; wd = 0; re = 0; ra = 0; cr = 0;
    ad[0] = 0; ad[1] = 0;
    apply();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    read_all("reset");

    cyc(1, 5, 16'hBEEF, 0, 0, 0, 5, 4, "bypass_r5");
    idle(5, 4, "after_r5");

    cyc(1, 0, 16'h1234, 1, 0, 0, 0, 5, "zero_wr_rsv");
    idle(0, 5, "zero_after");

    cyc(0, 0, 0, 1, 3, 0, 3, 0, "rsv_r3");
    cyc(0, 0, 0, 1, 3, 0, 3, 0, "rsv_r3_again");
    cyc(1, 3, 16'h00AA, 0, 3, 0, 3, 1, "wr_r3");
    idle(3, 1, "r3_cleared");
    cyc(1, 3, 16'h0BCD, 1, 3, 0, 3, 2, "rsv_wr_r3");
    idle(3, 2, "r3_rsv_wins");

    for (int j = 1; j < DEPTH; j++)
      cyc(1, AW'(j), 16'h1000 + 16'(j * 16'h0111), 0, 0, 0, AW'(j), AW'(j - 1), "fill");
    cyc(0, 0, 0, 1, 9, 0, 9, 8, "rsv_r9");

    cyc(1, 2, 16'h2222, 0, 0, 1, 2, 9, "clr_req");
    sweep_hi = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (bus0.clr_busy) sweep_hi++;
      cyc(1, AW'($urandom_range(0, 15)), 16'($urandom), 1, AW'($urandom_range(0, 15)), 1,
          AW'($urandom_range(0, 15)), AW'(j), "sweep");
    end
    chk("sweep_len", 32'(sweep_hi), 32'(DEPTH));
    cyc(1, 7, 16'h5555, 0, 0, 0, 7, 9, "post_sweep_wr");
    read_all("post_sweep");

    for (int j = 1; j < DEPTH; j++)
      cyc(1, AW'(j), 16'($urandom) | 16'h1, 1, AW'(j), 0, AW'(j), 0, "refill");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "clr_req2");
    for (int j = 0; j < 7; j++) idle(AW'(j + 4), AW'(j + 8), "sweep7");
    we = 0; re = 0; cr = 0;
    apply();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid/d0.clr_busy", 32'(bus0.clr_busy), 32'd0);
    chk("rst_mid/d1.clr_busy", 32'(bus1.clr_busy), 32'd0);
    check_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    read_all("after_rst");

    cyc(1, 6, 16'h6666, 1, 4, 0, 6, 4, "pre_clr3");
    cyc(0, 0, 0, 0, 0, 1, 6, 4, "clr_req3");
    for (int j = 0; j < DEPTH; j++) idle(6, 4, "sweep3");
    read_all("after_clr3");

    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] rwa;
      rwa = AW'($urandom_range(0, 15));
      cyc($urandom_range(0, 1) == 1, rwa, 16'($urandom),
          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
          $urandom_range(0, 39) == 0,
          ($urandom_range(0, 2) == 0) ? rwa : AW'($urandom_range(0, 15)),
          AW'($urandom_range(0, 15)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
